// File: rtl/fifo_pkg.sv
// Shared types for the fifo / word packer datapath.
package fifo_pkg;

    typedef enum logic {FILL, HOLD} pack_state_t;

endpackage

// File: rtl/fifo_word_packer.sv
// Pops narrow FWFT fifo words and packs them, oldest in the LSBs,
// into wide words on a valid/ready stream; flush emits a partial word.
module fifo_word_packer
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH  = 4,
    parameter int PACK_RATIO  = 4,
    parameter int COUNT_WIDTH = 3
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             clr,
    input  logic [DATA_WIDTH-1:0]            din,
    input  logic                             empty_n,
    output logic                             deq,
    input  logic                             flush,
    output logic [DATA_WIDTH*PACK_RATIO-1:0] out_data,
    output logic [COUNT_WIDTH-1:0]           out_count,
    output logic                             out_valid,
    input  logic                             out_ready
);

    localparam int LANE_W = $clog2(PACK_RATIO);
    localparam logic [COUNT_WIDTH-1:0] LAST = COUNT_WIDTH'(PACK_RATIO - 1);

    pack_state_t state;
    pack_state_t state_nxt;

    logic [COUNT_WIDTH-1:0]                cnt;
    logic [PACK_RATIO-1:0][DATA_WIDTH-1:0] lanes;
    logic [PACK_RATIO-1:0][DATA_WIDTH-1:0] lanes_fill;
    logic [PACK_RATIO-1:0][DATA_WIDTH-1:0] word_q;
    logic [LANE_W-1:0]                     idx;
    logic                                  load;

    assign idx      = cnt[LANE_W-1:0];
    assign out_data = word_q;

    // A word leaves FILL when its last lane lands or a flush finds data.
    assign load = (state == FILL) &&
                  ((deq && cnt == LAST) ||
                   (flush && (cnt != '0 || deq)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FILL;
        end else if (clr) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            FILL: if (load) state_nxt = HOLD;
            HOLD: if (out_ready) state_nxt = FILL;
            default: state_nxt = FILL;
        endcase
    end

    always_comb begin
        deq = 1'b0;
        if (rst_n && !clr) begin
            unique case (state)
                FILL: deq = empty_n;
                HOLD: deq = empty_n & out_ready;
                default: deq = 1'b0;
            endcase
        end
    end

    always_comb begin
        lanes_fill = lanes;
        if (deq) lanes_fill[idx] = din;
    end

    // Lanes are cleared on entering HOLD, so idx is 0 at the handshake pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            lanes     <= '0;
            word_q    <= '0;
            out_count <= '0;
            out_valid <= 1'b0;
        end else if (clr) begin
            cnt       <= '0;
            lanes     <= '0;
            word_q    <= '0;
            out_count <= '0;
            out_valid <= 1'b0;
        end else begin
            unique case (state)
                FILL: begin
                    if (load) begin
                        word_q    <= lanes_fill;
                        out_count <= cnt + COUNT_WIDTH'(deq);
                        out_valid <= 1'b1;
                        lanes     <= '0;
                        cnt       <= '0;
                    end else if (deq) begin
                        lanes <= lanes_fill;
                        cnt   <= cnt + COUNT_WIDTH'(1);
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        word_q    <= '0;
                        out_count <= '0;
                        out_valid <= 1'b0;
                        lanes     <= lanes_fill;
                        cnt       <= COUNT_WIDTH'(deq);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_word_packer.sv
// Randomised scoreboard bench for fifo_word_packer with a queue-based
// reference model of the pop / pack / flush / clear rules.
module tb_fifo_word_packer;

    localparam int DW = 4;
    localparam int PR = 4;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clr = 1'b0;
    logic [DW-1:0] din = '0;
    logic          empty_n = 1'b0;
    logic          deq;
    logic          flush = 1'b0;
    logic [DW*PR-1:0] out_data;
    logic [CW-1:0] out_count;
    logic          out_valid;
    logic          out_ready = 1'b0;

    fifo_word_packer #(
        .DATA_WIDTH (DW),
        .PACK_RATIO (PR),
        .COUNT_WIDTH(CW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .din      (din),
        .empty_n  (empty_n),
        .deq      (deq),
        .flush    (flush),
        .out_data (out_data),
        .out_count(out_count),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW*PR-1:0] d;
        logic [CW-1:0]    c;
    } pkt_t;

    int            checks = 0;
    int            failures = 0;
    logic [DW-1:0] src[$];
    logic [DW-1:0] pend[$];
    pkt_t          exp_q[$];
    bit            held = 1'b0;
    logic [DW*PR-1:0] last_data = '0;
    logic [CW-1:0] last_count = '0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t",
                     name, act, req, $time);
        end
    endtask

    function automatic pkt_t make_pkt();
        pkt_t p;
        p.d = '0;
        for (int i = 0; i < pend.size(); i++) p.d[DW*i +: DW] = pend[i];
        p.c = CW'(pend.size());
        return p;
    endfunction

    // Reference model: evaluated just before each rising edge.
    initial begin
        forever begin
            bit exp_deq;
            bit was_held;
            @(negedge clk);
            #3;
            if (!rst_n) begin
                pend.delete();
                exp_q.delete();
                held = 1'b0;
            end else begin
                exp_deq = !clr && empty_n && (!held || out_ready);
                chk("deq", {31'd0, deq}, {31'd0, exp_deq});
                chk("out_valid", {31'd0, out_valid}, {31'd0, held});
                if (clr) begin
                    if (held && exp_q.size() > 0) void'(exp_q.pop_back());
                    held = 1'b0;
                    pend.delete();
                end else begin
                    was_held = held;
                    if (held && out_ready) held = 1'b0;
                    if (exp_deq && src.size() > 0) pend.push_back(src[0]);
                    if (!was_held &&
                        (pend.size() == PR || (flush && pend.size() > 0))) begin
                        exp_q.push_back(make_pkt());
                        held = 1'b1;
                        pend.delete();
                    end
                end
                if (deq && src.size() > 0) void'(src.pop_front());
            end
        end
    end

    // Monitor: compares each accepted wide word against the scoreboard.
    initial begin
        forever begin
            pkt_t e;
            @(negedge clk);
            #2;
            if (rst_n && !clr && out_valid && out_ready) begin
                last_data  = out_data;
                last_count = out_count;
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", {16'd0, out_data}, {16'd0, e.d});
                    chk("out_count", {29'd0, out_count}, {29'd0, e.c});
                end
            end
        end
    end

    task automatic cyc(input bit rdy, input bit fl, input bit cl,
                       input bit gap);
        @(negedge clk);
        #1;
        out_ready = rdy;
        flush     = fl;
        clr       = cl;
        empty_n   = !gap && src.size() != 0;
        din       = empty_n ? src[0] : '0;
    endtask

    task automatic push4(input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [DW-1:0] c, input logic [DW-1:0] d);
        src.push_back(a);
        src.push_back(b);
        src.push_back(c);
        src.push_back(d);
    endtask

    initial begin
        #1;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_count", {29'd0, out_count}, 32'd0);
        chk("rst_data", {16'd0, out_data}, 32'd0);
        chk("rst_deq", {31'd0, deq}, 32'd0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;

        // Four consecutive words form one full word.
        push4(4'hC, 4'hA, 4'h5, 4'h3);
        repeat (8) cyc(1, 0, 0, 0);
        chk("t1_data", {16'd0, last_data}, 32'h35AC);
        chk("t1_count", {29'd0, last_count}, 32'd4);

        // Back-pressure with more words queued, then release.
        push4(4'h1, 4'h2, 4'h3, 4'h4);
        push4(4'h5, 4'h6, 4'h7, 4'h8);
        repeat (12) cyc(0, 0, 0, 0);
        repeat (12) cyc(1, 0, 0, 0);
        chk("t2_data", {16'd0, last_data}, 32'h8765);

        // Partial flush, then a flush with nothing collected.
        src.push_back(4'hC);
        src.push_back(4'hA);
        repeat (2) cyc(1, 0, 0, 0);
        cyc(1, 1, 0, 0);
        repeat (3) cyc(1, 0, 0, 0);
        chk("t3_data", {16'd0, last_data}, 32'h00AC);
        chk("t3_count", {29'd0, last_count}, 32'd2);
        cyc(1, 1, 0, 0);
        repeat (3) cyc(1, 0, 0, 0);

        // Clear after three lanes, then a fresh word.
        src.push_back(4'h7);
        src.push_back(4'h8);
        src.push_back(4'h9);
        repeat (3) cyc(1, 0, 0, 0);
        cyc(1, 0, 1, 0);
        push4(4'h1, 4'h2, 4'h3, 4'h4);
        repeat (8) cyc(1, 0, 0, 0);
        chk("t4_data", {16'd0, last_data}, 32'h4321);

        // Asynchronous reset while a word is held.
        push4(4'hE, 4'hD, 4'hB, 4'h9);
        repeat (7) cyc(0, 0, 0, 0);
        chk("t5_held", {31'd0, out_valid}, 32'd1);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("t5_valid", {31'd0, out_valid}, 32'd0);
        chk("t5_count", {29'd0, out_count}, 32'd0);
        chk("t5_deq", {31'd0, deq}, 32'd0);
        src.delete();
        cyc(0, 0, 0, 0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        push4(4'h2, 4'h4, 4'h6, 4'h8);
        repeat (8) cyc(1, 0, 0, 0);
        chk("t5_data", {16'd0, last_data}, 32'h8642);

        // Random producer gaps, back-pressure, flushes and clears.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(2) == 0 && src.size() < 8)
                src.push_back(DW'($urandom));
            cyc($urandom_range(3) != 0, $urandom_range(11) == 0,
                $urandom_range(79) == 0, $urandom_range(3) == 0);
        end

        // Drain everything still queued or partially packed.
        repeat (20) cyc(1, 0, 0, 0);
        cyc(1, 1, 0, 0);
        repeat (6) cyc(1, 0, 0, 0);
        chk("drain_src", src.size(), 32'd0);
        chk("drain_exp", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
